// File: rtl/mult_unit_seq.sv
// mult_unit_seq: multi-cycle signed/unsigned multiplier, radix-2^BITS_PER_CYCLE shift-add
// over operand magnitudes with a final sign fix.
module mult_unit_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 flush,
  input  logic                 unsigned_mode,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   mult_result
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  logic [1:0]           state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d, res_q, res_d, partial;
  logic [WIDTH-1:0]     mplier_q, mplier_d, mag1, mag2;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d, done_q, done_d;
  always_comb begin
    mag1     = (~unsigned_mode & op1[WIDTH-1]) ? -op1 : op1;
    mag2     = (~unsigned_mode & op2[WIDTH-1]) ? -op2 : op2;
    // multiplicand is pre-shifted each iteration, so the digit product lands at its weight
    partial  = mcand_q * (2*WIDTH)'(mplier_q[BITS_PER_CYCLE-1:0]);
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    res_d    = res_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start && !flush) begin
        state_d  = CALC;
        mcand_d  = {{WIDTH{1'b0}}, mag1};
        mplier_d = mag2;
        neg_d    = ~unsigned_mode & (op1[WIDTH-1] ^ op2[WIDTH-1]);
        acc_d    = '0;
        cnt_d    = '0;
      end
      CALC: if (flush) state_d = IDLE;
      else begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + CW'(1);
        state_d  = (cnt_q == CW'(N - 1)) ? FIX : CALC;
      end
      FIX: begin
        state_d = IDLE;
        res_d   = flush ? res_q : (neg_q ? -acc_q : acc_q);
        done_d  = ~flush;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end
  assign ready       = (state_q == IDLE);
  assign busy        = ~ready;
  assign done        = done_q;
  assign mult_result = res_q;
endmodule

// File: tb/tb_mult_unit_seq.sv
// tb_mult_unit_seq: checks radix-2 and radix-16 instances against an arithmetic product model.
module tb_mult_unit_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0, flush = 1'b0, mode = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        ready1, busy1, done1, ready4, busy4, done4;
  logic [63:0] res1, res4, prev1, prev4;
  int          errs = 0, checks = 0;

  always #5 clk = ~clk;

  mult_unit_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .flush(flush), .unsigned_mode(mode),
    .op1(op1), .op2(op2), .ready(ready1), .busy(busy1), .done(done1), .mult_result(res1));
  mult_unit_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .flush(flush), .unsigned_mode(mode),
    .op1(op1), .op2(op2), .ready(ready4), .busy(busy4), .done(done4), .mult_result(res4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic m, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = m ? $signed({32'b0, a}) : $signed({{32{a[31]}}, a});
    sb = m ? $signed({32'b0, b}) : $signed({{32{b[31]}}, b});
    return 64'(sa * sb);
  endfunction

  task automatic idle_checks(input string tag, input logic [63:0] e1, input logic [63:0] e4);
    chk({tag, "_ready1"}, 64'(ready1), 64'd1);
    chk({tag, "_busy1"}, 64'(busy1), 64'd0);
    chk({tag, "_done1"}, 64'(done1), 64'd0);
    chk({tag, "_res1"}, res1, e1);
    chk({tag, "_ready4"}, 64'(ready4), 64'd1);
    chk({tag, "_done4"}, 64'(done4), 64'd0);
    chk({tag, "_res4"}, res4, e4);
  endtask

  task automatic no_done(input string tag, input int cycles);
    int n = 0;
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      n += int'(done1) + int'(done4);
    end
    chk(tag, 64'(n), 64'd0);
  endtask

  task automatic do_op(input string tag, input logic m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp, r1, r4;
    int n1 = 0, n4 = 0, l1 = -1, l4 = -1;
    exp = ref_mul(m, a, b);
    mode = m; op1 = a; op2 = b; start1 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    r1 = '0; r4 = '0;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      if (j == 3) begin
        mode = $urandom_range(0, 1); op1 = $urandom; op2 = $urandom; start1 = 1'b1; start4 = 1'b1;
      end else begin
        start1 = 1'b0; start4 = 1'b0;
      end
      if (done1) begin n1++; l1 = j; r1 = res1; end
      if (done4) begin n4++; l4 = j; r4 = res4; end
    end
    chk({tag, "_n1"}, 64'(n1), 64'd1);
    chk({tag, "_lat1"}, 64'(l1), 64'd33);
    chk({tag, "_r1"}, r1, exp);
    chk({tag, "_n4"}, 64'(n4), 64'd1);
    chk({tag, "_lat4"}, 64'(l4), 64'd9);
    chk({tag, "_r4"}, r4, exp);
    chk({tag, "_hold1"}, res1, exp);
    chk({tag, "_hold4"}, res4, exp);
    prev1 = exp; prev4 = exp;
  endtask

  initial begin
    int nd, d1j, d2j;
    logic [63:0] b2b1, b2b2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_checks("reset", 64'd0, 64'd0);

    mode = 1'b1; op1 = 32'd1234; op2 = 32'd5678; start1 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_checks("midrst", 64'd0, 64'd0);
    no_done("midrst_nodone", 40);
    prev1 = '0; prev4 = '0;

    do_op("neg3x7", 1'b0, 32'hFFFF_FFFD, 32'd7);
    chk("neg3x7_const", res1, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("umax", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("umax_const", res4, 64'hFFFF_FFFE_0000_0001);
    do_op("minxmin", 1'b0, 32'h8000_0000, 32'h8000_0000);
    chk("minxmin_const", res1, 64'h4000_0000_0000_0000);
    do_op("minxm1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("minxm1_const", res4, 64'h0000_0000_8000_0000);
    for (int i = 0; i < 12; i++)
      do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom);

    mode = 1'b1; op1 = 32'd5; op2 = 32'd6; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    nd = 0; d1j = -1; d2j = -1; b2b1 = '0; b2b2 = '0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) begin
        nd++;
        if (d1j < 0) begin
          d1j = j; b2b1 = res4;
          mode = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'd2; start4 = 1'b1;
        end else begin
          d2j = j; b2b2 = res4;
        end
      end
      if (d1j > 0 && j == d1j + 4) begin
        op1 = 32'd77; op2 = 32'd77; start4 = 1'b1;
      end
      if (d1j > 0 && j == d1j + 6) chk("b2b_held", res4, 64'd30);
    end
    chk("b2b_ndone", 64'(nd), 64'd2);
    chk("b2b_r1", b2b1, ref_mul(1'b1, 32'd5, 32'd6));
    chk("b2b_r2", b2b2, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("b2b_gap", 64'(d2j - d1j), 64'd10);
    prev4 = b2b2;

    mode = 1'b1; op1 = 32'd9; op2 = 32'd9; start1 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle_checks("flush", prev1, prev4);
    no_done("flush_nodone", 40);
    do_op("flush_after", 1'b1, 32'd9, 32'd9);
    chk("flush_after_81", res1, 64'd81);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mult_unit_seq.md
Name: mult_unit_seq

Overview:
- Parametrised multi-cycle integer multiplier, signed or unsigned; next generation of the single-cycle combinational multiply unit.
- Computes a 2*WIDTH-bit product by radix-2^BITS_PER_CYCLE shift-add iteration over magnitudes, then applies a final sign fix.
- Sits beside the ALU and feeds the HI/LO registers.
- The control unit stalls the pipeline until done is asserted.

Parameters:
- WIDTH, 32, operand width in bits; even, >= 4.
- BITS_PER_CYCLE, 1, multiplier bits consumed per iteration; must be 1, 2 or 4 and divide WIDTH.
- N (localparam), WIDTH/BITS_PER_CYCLE, number of iterations.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  request; accepted only when ready=1.
- flush  in  1  synchronous abort of an in-flight operation.
- unsigned_mode  in  1  1 = unsigned multiply, 0 = two's-complement signed multiply; sampled with start.
- op1  in  WIDTH  multiplicand; sampled with start.
- op2  in  WIDTH  multiplier; sampled with start.
- ready  out  1  unit idle; can accept start.
- busy  out  1  operation in flight; equals ~ready.
- done  out  1  one-cycle pulse; mult_result valid and updated.
- mult_result  out  2*WIDTH  product; holds its value until the next completion.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, ready=1, busy=0, done=0, mult_result=0.
  - All internal accumulator, operand and sign registers cleared.
  - Reset mid-operation discards the operation; no done is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - ready=1.
  - On an edge with start=1 and flush=0:
    - capture mag1 = (~unsigned_mode & op1[WIDTH-1]) ? -op1 : op1, mag2 likewise from op2, each as a WIDTH-bit unsigned value;
    - capture neg = ~unsigned_mode & (op1[WIDTH-1]^op2[WIDTH-1]);
    - clear the accumulator and iteration counter; go to CALC.
  - start with flush=1 is ignored.
- CALC:
  - Each edge adds mag1 * (next BITS_PER_CYCLE LSBs of the multiplier shift register) into the 2*WIDTH-bit accumulator at the correct weight.
  - Shifts the multiplier right by BITS_PER_CYCLE and increments the counter.
  - After the N-th iteration edge, go to FIX.
  - Accumulator arithmetic is 2*WIDTH bits; no overflow is possible.
- FIX:
  - On one edge: mult_result <= neg ? -acc : acc (2*WIDTH-bit two's complement); done <= 1; state <= IDLE.
- done:
  - High exactly one cycle, namely the first IDLE cycle after FIX.
  - Cleared on the following edge unless another FIX occurs.
- Latency:
  - start accepted at edge k; done high in the cycle after edge k+N+1.
  - WIDTH=32, BITS_PER_CYCLE=1: done after edge k+33.
  - WIDTH=32, BITS_PER_CYCLE=4: done after edge k+9.
- Back-to-back: start may be accepted in the cycle where done=1 (ready=1). That edge captures new operands; the old mult_result stays held until the new FIX.
- start while busy=1: ignored, no effect, not queued.
- Operand changes while busy: no effect; operands are registered.
- flush:
  - In CALC or FIX, flush=1 forces IDLE on the next edge.
  - mult_result unchanged; done not asserted.
  - flush in IDLE: no effect.
  - flush wins over FIX completion.
- Most-negative operand (signed, e.g. 0x80000000): the magnitude 2^(WIDTH-1) is represented correctly as unsigned WIDTH bits; the product is exact.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

Test Plan:
- Reset mid-CALC, then release → ready=1, done=0, mult_result=0, and no spurious done in the following 40 cycles.
- WIDTH=32, BPC=1, signed op1=-3 (0xFFFFFFFD), op2=7, start at edge k → done only in the cycle after edge k+33; mult_result=0xFFFFFFFF_FFFFFFEB.
- Unsigned op1=op2=0xFFFFFFFF → mult_result=0xFFFFFFFE_00000001.
- Signed corner cases, each producing exactly one done:
  - 0x80000000*0x80000000 → 0x40000000_00000000;
  - 0x80000000*0xFFFFFFFF → 0x00000000_80000000.
- Back-to-back, BPC=4: issue 5*6 unsigned, then start 0xFFFFFFFF*2 signed in the done cycle.
  - Both results correct (30, then 0xFFFFFFFF_FFFFFFFE).
  - done pulses are 10 cycles apart.
  - A start pulsed mid-operation is ignored.
- Issue 9*9, assert flush on the 5th CALC cycle → no done, mult_result keeps its previous value, ready=1 on the next cycle; a subsequent 9*9 gives 81.
